// File: rtl/accel_if_pkg.sv
// Shared definitions for the accelerator AXI4-Lite front-end: address map,
// response codes, FSM states and the local offset decoder.
package accel_if_pkg;

  localparam int CTRL_WORDS   = 4;
  localparam int STATUS_WORDS = 4;

  localparam logic [12:0] CTRL_BASE   = 13'h1000;
  localparam logic [12:0] STATUS_BASE = 13'h1010;
  localparam logic [12:0] MAP_END     = 13'h1020;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACCEPT,
    S_WR_RESP,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_RESP
  } state_e;

  typedef enum logic [1:0] {
    REGION_MEM,
    REGION_CTRL,
    REGION_STATUS,
    REGION_NONE
  } region_e;

  typedef struct packed {
    region_e    region;
    logic [1:0] idx;
  } decode_t;

  // Takes the word offset (byte offset bits [12:2]); bit 12 clear is memory.
  function automatic decode_t decode(input logic [10:0] word_off);
    decode_t     d;
    logic [12:0] a;
    a        = {word_off, 2'b00};
    d.idx    = word_off[1:0];
    d.region = REGION_NONE;
    if (!a[12])                                d.region = REGION_MEM;
    else if (a >= CTRL_BASE && a < STATUS_BASE) d.region = REGION_CTRL;
    else if (a >= STATUS_BASE && a < MAP_END)   d.region = REGION_STATUS;
    return d;
  endfunction

endpackage

// File: rtl/accel_ctrl_regs.sv
// Control register file with byte-masked writes, the self-clearing start
// bit in ctrl0[0], and the sticky done flag.
module accel_ctrl_regs
  import accel_if_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [1:0]              wr_idx,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_strb,
  input  logic                    done_i,
  output logic [CTRL_WORDS*32-1:0] ctrl_o,
  output logic                    start_o,
  output logic                    done_sticky_o
);

  logic [31:0] ctrl_q [CTRL_WORDS];
  logic [31:0] ctrl_d [CTRL_WORDS];
  logic        start_q, start_d;
  logic        done_sticky_q, done_sticky_d;

  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ctrl_d  = ctrl_q;
    start_d = 1'b0;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) ctrl_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
      if (wr_idx == 2'd0) begin
        start_d        = wr_strb[0] & wr_data[0];
        ctrl_d[0][0]   = 1'b0;
      end
    end
    // A done arriving with the start pulse must not be lost.
    done_sticky_d = done_i | (done_sticky_q & ~start_q);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is only four words, so it is reset like any
      // other flop; large storage arrays would be left unreset.
      for (int i = 0; i < CTRL_WORDS; i++) ctrl_q[i] <= '0;
      start_q       <= 1'b0;
      done_sticky_q <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      start_q       <= start_d;
      done_sticky_q <= done_sticky_d;
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int i = 0; i < CTRL_WORDS; i++) ctrl_o[32*i +: 32] = ctrl_q[i];
  end

  assign start_o       = start_q;
  assign done_sticky_o = done_sticky_q;

endmodule

// File: rtl/accel_axi_lite_slave.sv
// AXI4-Lite slave front-end: one outstanding transaction, routed to the
// data-memory port, the control registers or the status words.
module accel_axi_lite_slave
  import accel_if_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_WIDTH = 20,
  localparam int MEM_IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             aw_valid,
  output logic                             aw_ready,
  input  logic [31:0]                      aw_addr,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [31:0]                      w_data,
  input  logic [3:0]                       w_strb,
  output logic                             b_valid,
  input  logic                             b_ready,
  output logic [1:0]                       b_resp,
  input  logic                             ar_valid,
  output logic                             ar_ready,
  input  logic [31:0]                      ar_addr,
  output logic                             r_valid,
  input  logic                             r_ready,
  output logic [31:0]                      r_data,
  output logic [1:0]                       r_resp,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [MEM_IDX_W-1:0]             mem_addr,
  output logic [MEM_WIDTH-1:0]             mem_wdata,
  input  logic [MEM_WIDTH-1:0]             mem_rdata,
  output logic [CTRL_WORDS*32-1:0]         ctrl_o,
  input  logic [(STATUS_WORDS-1)*32-1:0]   status_i,
  input  logic                             done_i,
  output logic                             start_o
);

  state_e      state_q, state_d;
  logic        rd_prio_q, rd_prio_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic [1:0]  b_resp_q, b_resp_d;

  logic        wr_pend;
  logic        ctrl_wr_en;
  logic        done_sticky;
  logic [31:0] status_word [STATUS_WORDS];
  decode_t     wr_dec, ar_dec, rd_dec;

  // The window base is decoded upstream; only offset bits [12:2] matter here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr[31:13], aw_addr[1:0], ar_addr[31:13], ar_addr[1:0]};

  assign wr_dec = decode(aw_addr[12:2]);
  assign ar_dec = decode(ar_addr[12:2]);
  assign rd_dec = decode(rd_addr_q);

  always_comb begin
    status_word[0] = {31'b0, done_sticky};
    for (int i = 1; i < STATUS_WORDS; i++) status_word[i] = status_i[32*(i-1) +: 32];
  end

  always_comb begin
    state_d    = state_q;
    rd_prio_d  = rd_prio_q;
    rd_addr_d  = rd_addr_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    b_resp_d   = b_resp_q;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    ar_ready   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ctrl_wr_en = 1'b0;
    mem_addr   = ar_addr[MEM_IDX_W+1:2];
    wr_pend    = aw_valid & w_valid;

    unique case (state_q)
      S_IDLE: begin
        // Priority only flips on contested grants, so it alternates under load.
        if (wr_pend && ar_valid) begin
          state_d   = rd_prio_q ? S_RD_ISSUE : S_WR_ACCEPT;
          rd_prio_d = ~rd_prio_q;
        end else if (wr_pend) begin
          state_d = S_WR_ACCEPT;
        end else if (ar_valid) begin
          state_d = S_RD_ISSUE;
        end
      end
      S_WR_ACCEPT: begin
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        mem_addr = aw_addr[MEM_IDX_W+1:2];
        b_resp_d = RESP_SLVERR;
        if (wr_dec.region == REGION_MEM) begin
          mem_req  = |w_strb[2:0];
          mem_we   = |w_strb[2:0];
          b_resp_d = RESP_OKAY;
        end else if (wr_dec.region == REGION_CTRL) begin
          ctrl_wr_en = 1'b1;
          b_resp_d   = RESP_OKAY;
        end
        state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (b_ready) state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        ar_ready  = 1'b1;
        rd_addr_d = ar_addr[12:2];
        mem_req   = (ar_dec.region == REGION_MEM);
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        r_resp_d = RESP_OKAY;
        case (rd_dec.region)
          REGION_MEM:    r_data_d = {{(32-MEM_WIDTH){1'b0}}, mem_rdata};
          REGION_CTRL:   r_data_d = ctrl_o[32*rd_dec.idx +: 32];
          REGION_STATUS: r_data_d = status_word[rd_dec.idx];
          default: begin
            r_data_d = '0;
            r_resp_d = RESP_SLVERR;
          end
        endcase
        state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (r_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_prio_q <= 1'b0;
      rd_addr_q <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      b_resp_q  <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      rd_prio_q <= rd_prio_d;
      rd_addr_q <= rd_addr_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      b_resp_q  <= b_resp_d;
    end
  end

  assign b_valid   = (state_q == S_WR_RESP);
  assign r_valid   = (state_q == S_RD_RESP);
  assign b_resp    = b_resp_q;
  assign r_resp    = r_resp_q;
  assign r_data    = r_data_q;
  assign mem_wdata = w_data[MEM_WIDTH-1:0];

  accel_ctrl_regs u_ctrl_regs (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (ctrl_wr_en),
    .wr_idx       (wr_dec.idx),
    .wr_data      (w_data),
    .wr_strb      (w_strb),
    .done_i       (done_i),
    .ctrl_o       (ctrl_o),
    .start_o      (start_o),
    .done_sticky_o(done_sticky)
  );

endmodule
